// File: rtl/synaptic_current_accumulator.sv
// -----------------------------------------------------------------------------
// synaptic_current_accumulator
//
// Purpose:
//   Sums weighted synaptic events into one signed current per neuron for the
//   running timestep. On a timestep tick the closing bank is drained to the
//   neuron array as a valid/ready stream of non-zero currents only. Two
//   accumulator banks ping-pong so events keep landing during a drain; the
//   event input is never stalled.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   syn_valid      synaptic event valid (always accepted)
//   syn_neuron_id  target neuron of the event
//   syn_weight     unsigned weight magnitude
//   syn_exc_inh    1 = excitatory (add), 0 = inhibitory (subtract)
//   timestep_tick  one-cycle pulse closing the timestep
//   out_valid      drained current valid
//   out_ready      neuron array accepts the current
//   out_neuron_id  neuron of out_current
//   out_current    signed summed current
//   flush_busy     drain in progress
//   flush_done     one-cycle pulse when a drain completes
//   sat_event      one-cycle pulse: an accumulation clamped
//   tick_dropped   one-cycle pulse: tick arrived while draining
// -----------------------------------------------------------------------------
module synaptic_current_accumulator #(
    parameter int NUM_NEURONS     = 64,
    parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS),
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ACC_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       syn_valid,
    input  logic [NEURON_ID_WIDTH-1:0] syn_neuron_id,
    input  logic [WEIGHT_WIDTH-1:0]    syn_weight,
    input  logic                       syn_exc_inh,
    input  logic                       timestep_tick,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURON_ID_WIDTH-1:0] out_neuron_id,
    output logic [ACC_WIDTH-1:0]       out_current,
    output logic                       flush_busy,
    output logic                       flush_done,
    output logic                       sat_event,
    output logic                       tick_dropped
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN     = 2'd1,
        FLUSH_END = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [NEURON_ID_WIDTH-1:0] LAST_IDX = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

    // Accumulator banks. Kept as registers (not block RAM) because reset must
    // clear every entry and the accumulate path is a same-cycle read-modify-write.
    logic [ACC_WIDTH-1:0] acc_reg [0:1][0:NUM_NEURONS-1];

    state_t                     state_reg, state_next;
    logic                       active_bank_reg, active_bank_next;
    logic [NEURON_ID_WIDTH-1:0] drain_idx_reg, drain_idx_next;
    logic                       out_valid_reg, out_valid_next;
    logic [NEURON_ID_WIDTH-1:0] out_id_reg, out_id_next;
    logic [ACC_WIDTH-1:0]       out_cur_reg, out_cur_next;
    logic                       flush_busy_reg, flush_busy_next;
    logic                       flush_done_reg, flush_done_next;
    logic                       sat_event_reg;
    logic                       tick_dropped_reg, tick_dropped_next;
    logic                       drain_clear;

    // ---------------- accumulate datapath ----------------
    logic                 drain_bank;
    logic [ACC_WIDTH-1:0] acc_cur;
    logic [ACC_WIDTH:0]   acc_ext;
    logic [ACC_WIDTH:0]   w_ext;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 overflow;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] drain_entry;

    assign drain_bank  = ~active_bank_reg;
    assign acc_cur     = acc_reg[active_bank_reg][syn_neuron_id];
    assign acc_ext     = {acc_cur[ACC_WIDTH-1], acc_cur};
    assign w_ext       = {{(ACC_WIDTH+1-WEIGHT_WIDTH){1'b0}}, syn_weight};
    assign sum_wide    = syn_exc_inh ? (acc_ext + w_ext) : (acc_ext - w_ext);
    // The widened sum left the ACC_WIDTH range iff its top two bits disagree;
    // the top bit then tells which rail to clamp to.
    assign overflow    = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign acc_sum     = overflow ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                  : sum_wide[ACC_WIDTH-1:0];
    assign drain_entry = acc_reg[drain_bank][drain_idx_reg];

    // Event writes go to the active bank while drain clears hit the other bank,
    // so the two writes never collide on one entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    acc_reg[b][n] <= '0;
                end
            end
            sat_event_reg <= 1'b0;
        end else begin
            if (syn_valid) begin
                acc_reg[active_bank_reg][syn_neuron_id] <= acc_sum;
            end
            if (drain_clear) begin
                acc_reg[drain_bank][drain_idx_reg] <= '0;
            end
            sat_event_reg <= syn_valid & overflow;
        end
    end

    // ---------------- control state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            active_bank_reg  <= 1'b0;
            drain_idx_reg    <= '0;
            out_valid_reg    <= 1'b0;
            out_id_reg       <= '0;
            out_cur_reg      <= '0;
            flush_busy_reg   <= 1'b0;
            flush_done_reg   <= 1'b0;
            tick_dropped_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            active_bank_reg  <= active_bank_next;
            drain_idx_reg    <= drain_idx_next;
            out_valid_reg    <= out_valid_next;
            out_id_reg       <= out_id_next;
            out_cur_reg      <= out_cur_next;
            flush_busy_reg   <= flush_busy_next;
            flush_done_reg   <= flush_done_next;
            tick_dropped_reg <= tick_dropped_next;
        end
    end

    // ---------------- next-state / output logic ----------------
    logic slot_free;
    assign slot_free = ~out_valid_reg | out_ready;

    always_comb begin
        state_next        = state_reg;
        active_bank_next  = active_bank_reg;
        drain_idx_next    = drain_idx_reg;
        out_valid_next    = out_valid_reg;
        out_id_next       = out_id_reg;
        out_cur_next      = out_cur_reg;
        flush_busy_next   = flush_busy_reg;
        flush_done_next   = 1'b0;
        tick_dropped_next = timestep_tick & flush_busy_reg;
        drain_clear       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (timestep_tick) begin
                    active_bank_next = ~active_bank_reg;
                    state_next       = DRAIN;
                    flush_busy_next  = 1'b1;
                    drain_idx_next   = '0;
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    if (drain_entry != '0) begin
                        out_valid_next = 1'b1;
                        out_id_next    = drain_idx_reg;
                        out_cur_next   = drain_entry;
                        drain_clear    = 1'b1;
                    end else begin
                        out_valid_next = 1'b0;
                    end
                    drain_idx_next = drain_idx_reg + NEURON_ID_WIDTH'(1);
                    if (drain_idx_reg == LAST_IDX) begin
                        state_next = FLUSH_END;
                    end
                end
            end
            FLUSH_END: begin
                // Wait for the last current to be taken before signalling done.
                if (slot_free) begin
                    out_valid_next  = 1'b0;
                    flush_done_next = 1'b1;
                    flush_busy_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_valid     = out_valid_reg;
    assign out_neuron_id = out_id_reg;
    assign out_current   = out_cur_reg;
    assign flush_busy    = flush_busy_reg;
    assign flush_done    = flush_done_reg;
    assign sat_event     = sat_event_reg;
    assign tick_dropped  = tick_dropped_reg;

endmodule
